// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the five-stage pipeline.
// Drives the PC enable and the enable/flush controls of the IF/ID, ID/EX, EX/MEM and
// MEM/WB registers. It resolves fetch misses, data-memory stalls, load-use hazards and
// MEM-stage redirects, and sequences the halt drain. Saturating stall and redirect
// counters are kept for performance debug.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   ihit_i, dhit_i       instruction / data memory ready for the current request
//   mem_req_i            EX/MEM holds a load or store
//   idex_memread_i       ID/EX holds a load, idex_rt_i is its destination
//   ifid_rs_i/rt_i       source registers of the instruction in IF/ID
//   redirect_i           taken branch/jump resolved in MEM
//   halt_id_i            IF/ID holds a halt
//   pc_en_o, *_enable_o  register advance controls (combinational)
//   *_flush_o            bubble insertion controls (combinational)
//   halted_o             registered, processor stopped
//   stall_cycles_o       registered saturating stall-cycle count
//   flush_count_o        registered saturating redirect count
module pipeline_ctrl (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        ihit_i,
   input  logic        dhit_i,
   input  logic        mem_req_i,
   input  logic        idex_memread_i,
   input  logic [4:0]  idex_rt_i,
   input  logic [4:0]  ifid_rs_i,
   input  logic [4:0]  ifid_rt_i,
   input  logic        redirect_i,
   input  logic        halt_id_i,
   output logic        pc_en_o,
   output logic        ifid_enable_o,
   output logic        idex_enable_o,
   output logic        exmem_enable_o,
   output logic        memwb_enable_o,
   output logic        ifid_flush_o,
   output logic        idex_flush_o,
   output logic        exmem_flush_o,
   output logic        halted_o,
   output logic [15:0] stall_cycles_o,
   output logic [15:0] flush_count_o
);

   typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

   state_e      state_q, state_d;
   logic [1:0]  dcnt_q, dcnt_d;
   logic        halted_q;
   logic [15:0] stall_q, flush_q;
   logic        stall_inc, flush_inc;
   logic        dstall, lu;

   assign dstall = mem_req_i & ~dhit_i;
   assign lu     = idex_memread_i & (idex_rt_i != 5'd0) &
                   ((idex_rt_i == ifid_rs_i) | (idex_rt_i == ifid_rt_i));

   always_comb begin
      pc_en_o        = ihit_i;
      ifid_enable_o  = 1'b1;
      idex_enable_o  = 1'b1;
      exmem_enable_o = 1'b1;
      memwb_enable_o = 1'b1;
      ifid_flush_o   = 1'b0;
      idex_flush_o   = 1'b0;
      exmem_flush_o  = 1'b0;
      state_d        = state_q;
      dcnt_d         = dcnt_q;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;

      unique case (state_q)
         StRun: begin
            if (dstall) begin
               // A pending redirect is held in the frozen EX/MEM and retires on dhit.
               pc_en_o        = 1'b0;
               ifid_enable_o  = 1'b0;
               idex_enable_o  = 1'b0;
               exmem_enable_o = 1'b0;
               memwb_enable_o = 1'b0;
               stall_inc      = 1'b1;
            end else if (redirect_i) begin
               pc_en_o       = 1'b1;
               ifid_flush_o  = 1'b1;
               idex_flush_o  = 1'b1;
               exmem_flush_o = 1'b1;
               flush_inc     = 1'b1;
            end else if (lu) begin
               pc_en_o       = 1'b0;
               ifid_enable_o = 1'b0;
               idex_flush_o  = 1'b1;
               stall_inc     = 1'b1;
            end else if (halt_id_i) begin
               // Halt moves on to ID/EX; fetch stops and the pipe drains behind it.
               pc_en_o      = 1'b0;
               ifid_flush_o = 1'b1;
               state_d      = StDrain;
               dcnt_d       = 2'd2;
            end else if (!ihit_i) begin
               pc_en_o      = 1'b0;
               ifid_flush_o = 1'b1;
               stall_inc    = 1'b1;
            end
         end
         StDrain: begin
            pc_en_o      = 1'b0;
            ifid_flush_o = 1'b1;
            if (dstall) begin
               ifid_enable_o  = 1'b0;
               idex_enable_o  = 1'b0;
               exmem_enable_o = 1'b0;
               memwb_enable_o = 1'b0;
               stall_inc      = 1'b1;
            end else if (redirect_i) begin
               // The halt was on the wrong path: cancel the drain.
               pc_en_o       = 1'b1;
               idex_flush_o  = 1'b1;
               exmem_flush_o = 1'b1;
               flush_inc     = 1'b1;
               state_d       = StRun;
               dcnt_d        = 2'd0;
            end else if (dcnt_q != 2'd0) begin
               dcnt_d = dcnt_q - 2'd1;
            end else begin
               state_d = StHalt;
            end
         end
         StHalt: begin
            pc_en_o        = 1'b0;
            ifid_enable_o  = 1'b0;
            idex_enable_o  = 1'b0;
            exmem_enable_o = 1'b0;
            memwb_enable_o = 1'b0;
         end
         default: state_d = StRun;
      endcase

      // Hold everything quiet while reset is asserted.
      if (!rst_ni) begin
         pc_en_o        = 1'b0;
         ifid_enable_o  = 1'b0;
         idex_enable_o  = 1'b0;
         exmem_enable_o = 1'b0;
         memwb_enable_o = 1'b0;
         ifid_flush_o   = 1'b0;
         idex_flush_o   = 1'b0;
         exmem_flush_o  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StRun;
         dcnt_q   <= 2'd0;
         halted_q <= 1'b0;
         stall_q  <= 16'd0;
         flush_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         dcnt_q   <= dcnt_d;
         halted_q <= (state_d == StHalt);
         if (stall_inc && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
         if (flush_inc && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
      end
   end

   assign halted_o       = halted_q;
   assign stall_cycles_o = stall_q;
   assign flush_count_o  = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: a cycle-level reference model (drain tracked as
// cycles remaining, counters as plain integers) compared every cycle, plus directed
// scenarios with literal expectations.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ihit, dhit, mem_req, idex_memread, redirect, halt_id;
   logic [4:0]  idex_rt, ifid_rs, ifid_rt;
   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic        ifid_fl, idex_fl, exmem_fl, halted;
   logic [15:0] stall_cycles, flush_count;

   always #5 clk = ~clk;

   pipeline_ctrl dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .ihit_i         (ihit),
      .dhit_i         (dhit),
      .mem_req_i      (mem_req),
      .idex_memread_i (idex_memread),
      .idex_rt_i      (idex_rt),
      .ifid_rs_i      (ifid_rs),
      .ifid_rt_i      (ifid_rt),
      .redirect_i     (redirect),
      .halt_id_i      (halt_id),
      .pc_en_o        (pc_en),
      .ifid_enable_o  (ifid_en),
      .idex_enable_o  (idex_en),
      .exmem_enable_o (exmem_en),
      .memwb_enable_o (memwb_en),
      .ifid_flush_o   (ifid_fl),
      .idex_flush_o   (idex_fl),
      .exmem_flush_o  (exmem_fl),
      .halted_o       (halted),
      .stall_cycles_o (stall_cycles),
      .flush_count_o  (flush_count)
   );

   // Reference model state.
   int  m_stall, m_flush, m_rem;
   bit  m_halted;
   logic md_dst, md_lu;
   int  n_cmp = 0, n_err = 0;
   logic [7:0] exp_v, act_v;

   assign md_dst = mem_req & ~dhit;
   assign md_lu  = idex_memread & (idex_rt != 5'd0) & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

   // Output vector: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl}
   function automatic logic [7:0] model_outs();
      if (!rst_n || m_halted) return 8'b0_0000_000;
      if (m_rem > 0) begin
         if (md_dst)   return 8'b0_0000_100;
         if (redirect) return 8'b1_1111_111;
         return 8'b0_1111_100;
      end
      if (md_dst)   return 8'b0_0000_000;
      if (redirect) return 8'b1_1111_111;
      if (md_lu)    return 8'b0_0111_010;
      if (halt_id)  return 8'b0_1111_100;
      if (!ihit)    return 8'b0_1111_100;
      return 8'b1_1111_000;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_stall  <= 0;
         m_flush  <= 0;
         m_rem    <= 0;
         m_halted <= 1'b0;
      end else if (!m_halted) begin
         if (m_rem > 0) begin
            if (md_dst) begin
               if (m_stall < 65535) m_stall <= m_stall + 1;
            end else if (redirect) begin
               if (m_flush < 65535) m_flush <= m_flush + 1;
               m_rem <= 0;
            end else begin
               m_rem <= m_rem - 1;
               if (m_rem == 1) m_halted <= 1'b1;
            end
         end else if (md_dst || (!redirect && (md_lu || (!halt_id && !ihit)))) begin
            if (m_stall < 65535) m_stall <= m_stall + 1;
         end else if (redirect) begin
            if (m_flush < 65535) m_flush <= m_flush + 1;
         end else if (halt_id) begin
            m_rem <= 3;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   // One clock: compare against the model mid-cycle, then advance past the next edge.
   task automatic tick();
      @(negedge clk);
      exp_v = model_outs();
      act_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl};
      n_cmp++;
      if (act_v !== exp_v || halted !== m_halted || stall_cycles !== 16'(m_stall) ||
          flush_count !== 16'(m_flush)) begin
         n_err++;
         $display("FAIL model at %0t: outs %b want %b, halted %b want %b, stall %0d want %0d, flush %0d want %0d",
                  $time, act_v, exp_v, halted, m_halted, stall_cycles, 16'(m_stall),
                  flush_count, 16'(m_flush));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0; idex_memread = 1'b0; redirect = 1'b0;
      halt_id = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (3) tick();
      chk("reset pc_en", 32'(pc_en), 32'd0);
      chk("reset enables", 32'({ifid_en, idex_en, exmem_en, memwb_en}), 32'd0);
      chk("reset halted", 32'(halted), 32'd0);
      rst_n = 1'b1;
      #1 chk("run pc_en", 32'(pc_en), 32'd1);
      repeat (2) tick();

      // Fetch miss for three cycles.
      ihit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("imiss pc_en/ifid_flush", 32'({pc_en, ifid_fl}), 32'b01);
         tick();
      end
      ihit = 1'b1;
      #1 chk("imiss recover pc_en", 32'(pc_en), 32'd1);
      chk("imiss stall count", 32'(stall_cycles), 32'd3);

      // Load-use hazard, then cleared, then r0 destination.
      idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd7;
      #1 chk("lu pc/ifid_en/idex_fl", 32'({pc_en, ifid_en, idex_fl}), 32'b001);
      tick();
      ifid_rs = 5'd9; ifid_rt = 5'd9;
      #1 chk("lu cleared pc_en", 32'(pc_en), 32'd1);
      chk("lu stall count", 32'(stall_cycles), 32'd4);
      tick();
      idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
      #1 chk("lu r0 pc_en", 32'(pc_en), 32'd1);
      tick();
      chk("lu r0 no stall", 32'(stall_cycles), 32'd4);
      idle();

      // Data stall with a redirect waiting behind it.
      mem_req = 1'b1; dhit = 1'b0; redirect = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("dstall freeze", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'd0);
         chk("dstall flush_count", 32'(flush_count), 32'd0);
         tick();
      end
      dhit = 1'b1;
      #1 chk("dhit redirect pc/flushes", 32'({pc_en, ifid_fl, idex_fl, exmem_fl}), 32'b1111);
      tick();
      chk("redirect flush_count", 32'(flush_count), 32'd1);
      chk("dstall stall count", 32'(stall_cycles), 32'd8);
      idle();
      repeat (2) tick();

      // Halt drain with one dstall cycle inside.
      halt_id = 1'b1;
      #1 chk("halt accept pc/ifid_fl", 32'({pc_en, ifid_fl, idex_en}), 32'b011);
      tick();
      halt_id = 1'b0;
      tick();
      mem_req = 1'b1; dhit = 1'b0;
      #1 chk("drain dstall idex_en", 32'(idex_en), 32'd0);
      tick();
      idle();
      tick();
      chk("drain extended halted", 32'(halted), 32'd0);
      tick();
      chk("halted after drain", 32'(halted), 32'd1);
      chk("halt stall count", 32'(stall_cycles), 32'd9);
      ihit = 1'b0; redirect = 1'b1; mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("halt frozen outs", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                                          ifid_fl, idex_fl, exmem_fl}), 32'd0);
         tick();
      end
      chk("halt frozen stall", 32'(stall_cycles), 32'd9);
      chk("halt frozen flush", 32'(flush_count), 32'd1);

      // Wrong-path halt cancelled by a redirect.
      rst_n = 1'b0;
      idle();
      tick();
      rst_n = 1'b1;
      tick();
      halt_id = 1'b1;
      tick();
      halt_id = 1'b0; redirect = 1'b1;
      #1 chk("wrong-path redirect outs", 32'({pc_en, ifid_fl, idex_fl, exmem_fl}), 32'b1111);
      tick();
      redirect = 1'b0;
      chk("wrong-path halted", 32'(halted), 32'd0);
      chk("wrong-path flush_count", 32'(flush_count), 32'd1);
      #1 chk("wrong-path back in run", 32'(pc_en), 32'd1);
      repeat (2) tick();
      chk("wrong-path still running", 32'(halted), 32'd0);

      // Reset in the second drain cycle, then counter saturation.
      halt_id = 1'b1;
      tick();
      halt_id = 1'b0;
      tick();
      rst_n = 1'b0;
      #1 chk("mid-drain reset flush_count", 32'(flush_count), 32'd0);
      chk("mid-drain reset pc_en", 32'(pc_en), 32'd0);
      tick();
      rst_n = 1'b1;
      #1 chk("after reset run pc_en", 32'(pc_en), 32'd1);
      tick();
      chk("after reset halted", 32'(halted), 32'd0);
      ihit = 1'b0;
      repeat (70000) tick();
      chk("stall saturation", 32'(stall_cycles), 32'h0000FFFF);
      chk("saturation pc_en", 32'(pc_en), 32'd0);
      ihit = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the five-stage pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC enable. It resolves instruction-fetch misses, data-memory stalls, load-use hazards and MEM-stage redirects, and sequences the halt drain. It also keeps saturating stall and flush counters for performance debug.

## Interface
- No parameters.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction memory returns valid imemload for the current PC this cycle.
- dhit  in  1  data memory completes the MEM-stage request this cycle.
- mem_req  in  1  EX/MEM holds a load or store.
- idex_memread  in  1  ID/EX holds a load.
- idex_rt  in  5  destination register of the load in ID/EX.
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in IF/ID.
- redirect  in  1  taken branch or jump resolved in MEM; the PC mux selects the target.
- halt_id  in  1  IF/ID holds a halt instruction.
- pc_en  out  1  PC loads its next value.
- ifid_enable, idex_enable, exmem_enable, memwb_enable  out  1 each  register advances.
- ifid_flush, idex_flush, exmem_flush  out  1 each  register loads a bubble. Flush takes priority over enable inside the register.
- halted  out  1  registered; the processor has stopped.
- stall_cycles  out  16  registered saturating stall-cycle count.
- flush_count  out  16  registered saturating redirect count.

## Operation
- FSM states: RUN, DRAIN, HALT. There is also a 2-bit drain counter, dcnt.
- Conditions:
  - dstall = mem_req & ~dhit.
  - lu = idex_memread & (idex_rt != 0) & (idex_rt == ifid_rs | idex_rt == ifid_rt).
- Defaults: all enables 1, all flushes 0, pc_en = ihit.
- RUN priority (highest first):
  - dstall: pc_en and all four enables are 0, no flushes. Count a stall.
  - redirect: pc_en=1 regardless of ihit. ifid_flush, idex_flush and exmem_flush are 1. flush_count++.
  - lu: pc_en=0, ifid_enable=0, idex_flush=1. Count a stall.
  - halt_id: pc_en=0, ifid_flush=1, idex_enable=1. Next state is DRAIN with dcnt=2.
  - ~ihit: pc_en=0, ifid_flush=1. Count a stall.
- DRAIN:
  - pc_en=0 and ifid_flush=1 every cycle.
  - dstall freezes the pipeline as in RUN; dcnt holds and a stall is counted.
  - redirect while draining means the halt was wrong-path. Apply the redirect outputs, increment flush_count, and return to RUN.
  - Otherwise, each cycle: if dcnt != 0, decrement dcnt; if dcnt == 0, go to HALT.
- HALT: all enables 0, all flushes 0, pc_en=0. Inputs are ignored, counters freeze, halted=1. The block stays in HALT until reset.
- Counters saturate at 16'hFFFF. At most one increment per counter per cycle.

## Timing
- Enables, flushes and pc_en are combinational from state and inputs, with zero-cycle latency.
- halted, the FSM state, dcnt and the counters update on the rising edge of CLK.
- While nRST is low, outputs are forced: all enables 0, all flushes 0, pc_en=0, halted=0, counters 0, state RUN.
- Reset may assert mid-DRAIN or mid-stall. The block always returns to RUN with no pending halt.
- Halt timing: if halt_id is accepted in cycle t with no later stalls, DRAIN covers cycles t+1 to t+3 and halted=1 from the edge ending t+3. Each dstall cycle in DRAIN adds one cycle.
- redirect together with dstall: dstall wins and redirect is held by the EX/MEM freeze. The redirect takes effect in the cycle dhit arrives.
- redirect together with lu or halt_id: redirect wins and the younger hazard is flushed.

## Test plan
- Fetch miss: ihit=0 for 3 cycles, then 1. Required: pc_en=0 and ifid_flush=1 for 3 cycles, then pc_en=1. stall_cycles=3.
- Load-use: idex_memread=1, idex_rt=5, ifid_rs=5, ihit=1. Required: pc_en=0, ifid_enable=0, idex_flush=1 for exactly one cycle once the hazard clears. With idex_rt=0, no stall occurs.
- Data stall with redirect: mem_req=1, dhit=0 for 4 cycles while redirect=1. Required: all enables 0 and flush_count=0 during the stall. On the dhit cycle, three flushes and pc_en=1, and flush_count=1.
- Halt drain: halt_id=1 at cycle 10, with a dstall cycle at 12. Required: DRAIN lasts 4 cycles, halted=1 after the edge ending cycle 14, and outputs then stay frozen.
- Wrong-path halt: halt_id at cycle 5, redirect at cycle 6. Required: state returns to RUN, halted stays 0, and flush_count increments by 1.
- Reset mid-DRAIN plus saturation: nRST low at cycle 2 of DRAIN clears halted, the counters and the state. Then 70000 ihit=0 cycles leave stall_cycles=16'hFFFF.
